// File: rtl/ph_transmit_credit_gate.sv
// ph_transmit_credit_gate: per-class transmit credit gate with a one-entry output register
module ph_transmit_credit_gate #(
  parameter int INFO_SIGNALS = 10,
  parameter int BYTES = 8,
  parameter int DW = 4 * BYTES,
  parameter int DATA_WIDTH = 5 * DW,
  parameter logic [2:0] BUFFER_TYPE = 3'b000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fc_valid,
  input  logic [INFO_SIGNALS+2:0]   fc_limit,
  input  logic                      tlp_valid,
  output logic                      tlp_ready,
  input  logic [DATA_WIDTH-1:0]     tlp_data,
  input  logic [2:0]                tlp_credits,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [DATA_WIDTH-1:0]     tx_data,
  output logic [INFO_SIGNALS-1:0]   credits_consumed,
  output logic [INFO_SIGNALS-1:0]   credit_limit,
  output logic                      infinite,
  output logic                      init_done,
  output logic                      fc_error
);
  localparam int N = INFO_SIGNALS;
  localparam logic [1:0] INIT = 2'd0, RUN = 2'd1, INF = 2'd2;
  localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};
  logic [1:0] state;
  logic [N-1:0] upd_lim, upd_room, room;
  logic match, pass, accept;
  assign upd_lim = fc_limit[N-1:0];
  assign match = fc_valid && fc_limit[N+2:N] == BUFFER_TYPE;
  // modular distance; anything beyond half range counts as negative
  assign upd_room = upd_lim - credits_consumed;
  assign room = credit_limit - (credits_consumed + N'(tlp_credits));
  assign pass = state == INF || (state == RUN && room <= HALF);
  assign tlp_ready = state != INIT && (!tx_valid || tx_ready) && pass;
  assign accept = tlp_valid && tlp_ready;
  assign infinite = state == INF;
  assign init_done = state != INIT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      tx_valid <= 1'b0;
      tx_data <= '0;
      credits_consumed <= '0;
      credit_limit <= '0;
      fc_error <= 1'b0;
    end else begin
      if (match) begin
        if (state == INIT) begin
          state <= upd_lim == '0 ? INF : RUN;
          credit_limit <= upd_lim;
        end else if (state == RUN) begin
          if (upd_room <= HALF) credit_limit <= upd_lim;
          else fc_error <= 1'b1;
        end else if (upd_lim != '0) fc_error <= 1'b1;
      end
      if (accept) begin
        tx_data <= tlp_data;
        tx_valid <= 1'b1;
        credits_consumed <= credits_consumed + N'(tlp_credits);
      end else if (tx_ready) tx_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ph_transmit_credit_gate.sv
// tb_ph_transmit_credit_gate: directed scenarios plus random traffic against a behavioural credit model
module tb_ph_transmit_credit_gate;
  logic clk = 0, rst = 1;
  logic fc_valid = 0, tlp_valid = 0, tx_ready = 0;
  logic [12:0] fc_limit = '0;
  logic [159:0] tlp_data = '0;
  logic [2:0] tlp_credits = '0;
  logic tlp_ready, tx_valid, infinite, init_done, fc_error;
  logic [159:0] tx_data;
  logic [9:0] credits_consumed, credit_limit;
  int vectors = 0, errs = 0;
  int m_init, m_inf, m_lim, m_cons, m_err, m_txv;
  logic [159:0] m_txd;

  ph_transmit_credit_gate dut (
    .clk(clk), .rst(rst), .fc_valid(fc_valid), .fc_limit(fc_limit),
    .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_data(tlp_data),
    .tlp_credits(tlp_credits), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .credits_consumed(credits_consumed),
    .credit_limit(credit_limit), .infinite(infinite), .init_done(init_done),
    .fc_error(fc_error));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int avail_ok(input int lim, input int used);
    return ((lim - used) & 1023) <= 512;
  endfunction

  function automatic logic exp_ready();
    return m_init != 0 && (m_txv == 0 || tx_ready) &&
           (m_inf != 0 || avail_ok(m_lim, m_cons + int'(tlp_credits)) != 0);
  endfunction

  task automatic model_reset();
    m_init = 0; m_inf = 0; m_lim = 0; m_cons = 0; m_err = 0; m_txv = 0; m_txd = '0;
  endtask

  task automatic check_all();
    chk("tlp_ready", 160'(tlp_ready), 160'(exp_ready()));
    chk("tx_valid", 160'(tx_valid), 160'(m_txv));
    chk("tx_data", tx_data, m_txd);
    chk("credits_consumed", 160'(credits_consumed), 160'(m_cons));
    chk("credit_limit", 160'(credit_limit), 160'(m_lim));
    chk("infinite", 160'(infinite), 160'(m_inf));
    chk("init_done", 160'(init_done), 160'(m_init));
    chk("fc_error", 160'(fc_error), 160'(m_err));
  endtask

  task automatic cyc(input logic v, input logic [2:0] ty, input int lim, input logic t, input int c, input logic r);
    logic rdy;
    int l;
    @(negedge clk);
    fc_valid = v; fc_limit = {ty, 10'(lim)}; tlp_valid = t; tlp_credits = 3'(c); tx_ready = r;
    tlp_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
    #1 check_all();
    rdy = exp_ready();
    l = lim & 1023;
    @(posedge clk);
    if (v && ty == 3'b000) begin
      if (m_init == 0) begin
        m_init = 1;
        if (l == 0) m_inf = 1; else m_lim = l;
      end else if (m_inf != 0) begin
        if (l != 0) m_err = 1;
      end else if (avail_ok(l, m_cons) != 0) m_lim = l;
      else m_err = 1;
    end
    if (t && rdy) begin
      m_txv = 1; m_txd = tlp_data; m_cons = (m_cons + c) & 1023;
    end else if (r) m_txv = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; fc_valid = 0; tlp_valid = 0; tx_ready = 0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    model_reset();
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 1, 1);
    cyc(1, 0, 4, 0, 0, 1);
    #1 chk("init_limit4", 160'({init_done, infinite, credit_limit}), 160'({1'b1, 1'b0, 10'd4}));
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 1, 1);
    #1 chk("cons_at_4", 160'(credits_consumed), 160'd4);
    cyc(1, 0, 6, 1, 1, 1);
    cyc(0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 1, 1, 1);
    #1 chk("cons_at_6", 160'(credits_consumed), 160'd6);
    cyc(1, 0, 8, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 3, 1);
    cyc(1, 0, 9, 1, 3, 1);
    cyc(0, 0, 0, 1, 3, 1);
    #1 chk("cons_at_9", 160'(credits_consumed), 160'd9);
    // wrap: walk credits_consumed up to 1020 with limit trailing ahead
    do_reset();
    cyc(1, 0, 300, 0, 0, 1);
    while (m_cons < 1020) cyc(1, 0, (m_cons + 300 > 1022) ? 1022 : m_cons + 300, 1, (1020 - m_cons > 7) ? 7 : 1020 - m_cons, 1);
    cyc(1, 0, 1022, 0, 0, 1);
    cyc(1, 0, 2, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 1);
    #1 chk("wrap_cons_err", 160'({fc_error, credits_consumed}), 160'({1'b0, 10'd0}));
    do_reset();
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2000; i++) cyc(0, 0, 0, 1, 1, 1);
    #1 chk("inf_cons", 160'(credits_consumed), 160'd976);
    cyc(1, 0, 5, 0, 0, 1);
    #1 chk("inf_err", 160'({fc_error, infinite}), 160'({1'b1, 1'b1}));
    do_reset();
    cyc(1, 0, 20, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 1, 50, 1, 1, 0);
    #1 chk("filter_limit", 160'(credit_limit), 160'd20);
    cyc(0, 0, 0, 0, 0, 1);
    do_reset();
    cyc(1, 0, 10, 0, 0, 1);
    cyc(0, 0, 0, 1, 5, 1);
    cyc(0, 0, 0, 1, 5, 1);
    cyc(1, 0, 5, 1, 0, 0);
    #1 chk("regress", 160'({fc_error, credit_limit}), 160'({1'b1, 10'd10}));
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      cyc($urandom_range(0, 3) == 0, ($urandom_range(0, 3) == 0) ? 3'b001 : 3'b000,
          (m_init == 0) ? (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 1023))
                        : (m_cons + $urandom_range(0, 560)) & 1023,
          $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0);
    end
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
